// File: rtl/rv32m_ext_unit_pkg.sv
// Shared types and constants for the external RV32 M-extension responder.
package rv32m_ext_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FINAL = 2'd2,
    ST_ACK   = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/rv32m_ext_unit_if.sv
// Hart-side M-extension request/response port.
interface rv32m_ext_unit_if;
  import rv32m_ext_unit_pkg::*;

  logic            i_EX_en;
  logic [XLEN-1:0] i_EX_rs1;
  logic [XLEN-1:0] i_EX_rs2;
  logic [2:0]      i_EX_f3;
  logic [XLEN-1:0] o_EX_res;
  logic            o_EX_ack;

  modport master (output i_EX_en, i_EX_rs1, i_EX_rs2, i_EX_f3,
                  input  o_EX_res, o_EX_ack);
  modport slave  (input  i_EX_en, i_EX_rs1, i_EX_rs2, i_EX_f3,
                  output o_EX_res, o_EX_ack);
endinterface

// File: rtl/rv32m_ext_unit_mdu_iter_core.sv
// Unsigned one-bit-per-cycle datapath shared by shift-add multiply and restoring divide.
module mdu_iter_core
  import rv32m_ext_unit_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_step,
  input  logic           i_is_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_done,
  output logic [2*W-1:0] o_prod,
  output logic [W-1:0]   o_quo,
  output logic [W-1:0]   o_rem
);
  localparam int CW = $clog2(W);

  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_is_div;

  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;
  logic [W:0]   w_sum;
  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;
  logic         w_ge;

  // Upper half is the running partial product (mul) or partial remainder (div).
  assign w_hi    = r_acc[2*W-1:W];
  assign w_lo    = r_acc[W-1:0];
  assign w_sum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_a} : {(W+1){1'b0}});
  assign w_shift = {w_hi, w_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[W-1:0] - r_b;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= '0;
      r_a      <= i_a;
      r_b      <= i_b;
      r_is_div <= i_is_div;
      r_acc    <= i_is_div ? {{W{1'b0}}, i_a} : {{W{1'b0}}, i_b};
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div)
        r_acc <= {(w_ge ? w_diff : w_shift[W-1:0]), w_lo[W-2:0], w_ge};
      else
        r_acc <= {w_sum, w_lo[W-1:1]};
    end
  end

  assign o_done = (r_cnt == CW'(W-1));
  assign o_prod = r_acc;
  assign o_quo  = w_lo;
  assign o_rem  = w_hi;

endmodule

// File: rtl/rv32m_ext_unit.sv
// External M-extension responder: sign handling, special cases and request FSM around mdu_iter_core.
module rv32m_ext_unit
  import rv32m_ext_unit_pkg::*;
#(
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  rv32m_ext_unit_if.slave   ex
);
  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t      r_state;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic [XLEN-1:0] r_res;
  logic            r_ack;

  logic            w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b, w_res_neg;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_div0, w_ovf, w_mul0, w_fast, w_start, w_done;
  logic [XLEN-1:0] w_fast_res;
  logic [2*XLEN-1:0] w_core_prod, w_prod;
  logic [XLEN-1:0] w_quo, w_rem, w_mag, w_dres, w_final;

  assign w_is_div  = ex.i_EX_f3[2];
  assign w_sgn_a   = (ex.i_EX_f3 == MDU_MULH) || (ex.i_EX_f3 == MDU_MULHSU) ||
                     (ex.i_EX_f3 == MDU_DIV)  || (ex.i_EX_f3 == MDU_REM);
  assign w_sgn_b   = (ex.i_EX_f3 == MDU_MULH) || (ex.i_EX_f3 == MDU_DIV) ||
                     (ex.i_EX_f3 == MDU_REM);
  assign w_neg_a   = w_sgn_a && ex.i_EX_rs1[XLEN-1];
  assign w_neg_b   = w_sgn_b && ex.i_EX_rs2[XLEN-1];
  assign w_abs_a   = w_neg_a ? -ex.i_EX_rs1 : ex.i_EX_rs1;
  assign w_abs_b   = w_neg_b ? -ex.i_EX_rs2 : ex.i_EX_rs2;
  // Remainder follows the dividend's sign; product and quotient follow the XOR.
  assign w_res_neg = (w_is_div && ex.i_EX_f3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  assign w_div0 = w_is_div && (ex.i_EX_rs2 == '0);
  assign w_ovf  = w_is_div && !ex.i_EX_f3[0] &&
                  (ex.i_EX_rs1 == W_MIN) && (ex.i_EX_rs2 == '1);
  assign w_mul0 = ZERO_FAST && !w_is_div &&
                  ((ex.i_EX_rs1 == '0) || (ex.i_EX_rs2 == '0));
  assign w_fast = w_div0 || w_ovf || w_mul0;
  assign w_fast_res = w_div0 ? (ex.i_EX_f3[1] ? ex.i_EX_rs1 : '1) :
                      w_ovf  ? (ex.i_EX_f3[1] ? '0 : W_MIN) : '0;

  assign w_start = (r_state == ST_IDLE) && ex.i_EX_en && !w_fast;

  mdu_iter_core #(.W(XLEN)) u_core (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_start),
    .i_step   (r_state == ST_BUSY),
    .i_is_div (w_is_div),
    .i_a      (w_abs_a),
    .i_b      (w_abs_b),
    .o_done   (w_done),
    .o_prod   (w_core_prod),
    .o_quo    (w_quo),
    .o_rem    (w_rem)
  );

  assign w_prod  = r_neg ? -w_core_prod : w_core_prod;
  assign w_mag   = r_f3[1] ? w_rem : w_quo;
  assign w_dres  = r_neg ? -w_mag : w_mag;
  assign w_final = r_f3[2] ? w_dres :
                   (r_f3 == MDU_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_f3    <= '0;
      r_neg   <= 1'b0;
      r_res   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex.i_EX_en) begin
            r_f3  <= ex.i_EX_f3;
            r_neg <= w_res_neg;
            if (w_fast) begin
              r_res   <= w_fast_res;
              r_ack   <= 1'b1;
              r_state <= ST_ACK;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (!ex.i_EX_en)
            r_state <= ST_IDLE;
          else if (w_done)
            r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          if (!ex.i_EX_en) begin
            r_state <= ST_IDLE;
          end else begin
            r_res   <= w_final;
            r_ack   <= 1'b1;
            r_state <= ST_ACK;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ex.o_EX_res = r_res;
  assign ex.o_EX_ack = r_ack;

endmodule

// File: tb/tb_rv32m_ext_unit.sv
// Bench for rv32m_ext_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_rv32m_ext_unit;
  import rv32m_ext_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32m_ext_unit_if ex_if ();

  rv32m_ext_unit #(.ZERO_FAST(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .ex    (ex_if)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res = '0;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit fast;
    if (f3[2])
      fast = (b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    else
      fast = (a == 0) || (b == 0);
    return fast ? 1 : XLEN + 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Issue one request; the ack must appear exactly off+lat cycles later with res held until then.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat, input int off, input bit keep);
    ex_if.i_EX_en  = 1'b1;
    ex_if.i_EX_rs1 = a;
    ex_if.i_EX_rs2 = b;
    ex_if.i_EX_f3  = f3;
    for (int k = 1; k <= off + lat; k++) begin
      @(posedge clk); #1;
      chk("ack_timing", {31'b0, ex_if.o_EX_ack}, {31'b0, (k == off + lat)});
      if (k < off + lat) chk("res_hold", ex_if.o_EX_res, last_res);
    end
    chk("result", ex_if.o_EX_res, exp_res);
    last_res = exp_res;
    if (!keep) begin
      ex_if.i_EX_en = 1'b0;
      @(posedge clk); #1;
      chk("ack_after", {31'b0, ex_if.o_EX_ack}, 32'd0);
    end
  endtask

  task automatic dir_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int lat);
    chk("model_res", ref_res(f3, a, b), r);
    chk("model_lat", ref_lat(f3, a, b), lat);
    run_op(f3, a, b, r, lat, 0, 1'b0);
  endtask

  // Request dropped after drop_k cycles, then `extra` cycles with no ack and res unchanged.
  task automatic abort_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int drop_k, input int extra);
    ex_if.i_EX_en  = 1'b1;
    ex_if.i_EX_rs1 = a;
    ex_if.i_EX_rs2 = b;
    ex_if.i_EX_f3  = f3;
    for (int k = 1; k <= drop_k + extra; k++) begin
      @(posedge clk); #1;
      chk("abort_ack", {31'b0, ex_if.o_EX_ack}, 32'd0);
      chk("abort_res", ex_if.o_EX_res, last_res);
      if (k == drop_k) ex_if.i_EX_en = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit keep, prev_keep;

    rst_n = 1'b0;
    ex_if.i_EX_en  = 1'b0;
    ex_if.i_EX_rs1 = '0;
    ex_if.i_EX_rs2 = '0;
    ex_if.i_EX_f3  = '0;
    #1;
    chk("reset_ack", {31'b0, ex_if.o_EX_ack}, 32'd0);
    chk("reset_res", ex_if.o_EX_res, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    dir_case(MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    dir_case(MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34);
    dir_case(MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    dir_case(MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    dir_case(MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    dir_case(MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    dir_case(MDU_DIVU,   32'd7,        32'd2,        32'd3,        34);
    dir_case(MDU_REMU,   32'd7,        32'd2,        32'd1,        34);
    dir_case(MDU_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 1);
    dir_case(MDU_REM,    32'd5,        32'd0,        32'd5,        1);
    dir_case(MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    dir_case(MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    dir_case(MDU_MULHU,  32'd0,        32'hDEADBEEF, 32'd0,        1);

    // Back-to-back: acks at cycles 34 and 69 of the first request.
    run_op(MDU_MUL, 32'd3, 32'd5, 32'd15, 34, 0, 1'b1);
    run_op(MDU_MUL, 32'h00012345, 32'h00001001, 32'h12357345, 34, 1, 1'b0);

    // Drop in BUSY at cycle 10, new DIV in cycle 12; then a drop in FINAL.
    abort_op(MDU_DIV, 32'd100, 32'd7, 10, 2);
    run_op(MDU_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, 0, 1'b0);
    abort_op(MDU_MULHU, 32'hFFFFFFFF, 32'h12345678, 33, 3);
    run_op(MDU_REMU, 32'd100, 32'd7, 32'd2, 34, 0, 1'b0);

    // Async reset mid-BUSY clears outputs without a clock edge.
    ex_if.i_EX_en  = 1'b1;
    ex_if.i_EX_rs1 = 32'd9;
    ex_if.i_EX_rs2 = 32'd9;
    ex_if.i_EX_f3  = MDU_MUL;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", {31'b0, ex_if.o_EX_ack}, 32'd0);
    chk("async_rst_res", ex_if.o_EX_res, 32'd0);
    ex_if.i_EX_en = 1'b0;
    last_res = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(MDU_MUL, 32'd9, 32'd9, 32'd81, 34, 0, 1'b0);

    prev_keep = 1'b0;
    for (int i = 0; i < 300; i++) begin
      f3   = 3'($urandom_range(0, 7));
      a    = pick();
      b    = pick();
      keep = (i != 299) && ($urandom_range(0, 3) == 0);
      run_op(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), prev_keep ? 1 : 0, keep);
      prev_keep = keep;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
